// File: rtl/fetch_unit_pipelined.sv
// Pipelined instruction fetch: owns the PC, drives a 1-cycle-latency instruction memory
// and hands instructions to decode through a 2-entry valid/ready queue.
module fetch_unit_pipelined #(
   parameter int                  PC_WIDTH     = 8,
   parameter int                  INSTR_WIDTH  = 32,
   parameter int                  PC_STEP      = 4,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic                   imem_en,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_rdata,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_target,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_WIDTH-1:0] out_instr,
   output logic [PC_WIDTH-1:0]    out_pc,
   output logic                   misaligned_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic                   inflight_q, inflight_d;
   logic [PC_WIDTH-1:0]    inflight_pc_q, inflight_pc_d;
   logic [1:0]             count_q, count_d;
   logic                   err_q, err_d;
   logic [INSTR_WIDTH-1:0] q_instr_q [2];
   logic [INSTR_WIDTH-1:0] q_instr_d [2];
   logic [PC_WIDTH-1:0]    q_pc_q [2];
   logic [PC_WIDTH-1:0]    q_pc_d [2];

   logic       pop;
   logic       issue;
   logic [1:0] count_after_pop;
   logic [2:0] occ_after_pop;

   // Entry 0 is always the head, so a pop shifts entry 1 down.
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      inflight_d      = inflight_q;
      inflight_pc_d   = inflight_pc_q;
      count_d         = count_q;
      err_d           = err_q;
      q_instr_d[0]    = q_instr_q[0];
      q_instr_d[1]    = q_instr_q[1];
      q_pc_d[0]       = q_pc_q[0];
      q_pc_d[1]       = q_pc_q[1];
      issue           = 1'b0;
      pop             = (count_q != 2'd0) && out_ready;
      count_after_pop = count_q - {1'b0, pop};
      occ_after_pop   = {1'b0, count_after_pop} + {2'b00, inflight_q};

      case (state_q)
         S_IDLE: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (redirect_valid) begin
               // Flush everything; the response of any outstanding read is dropped
               count_d    = 2'd0;
               inflight_d = 1'b0;
               if (redirect_target[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = S_FAULT;
               end else begin
                  pc_d = redirect_target;
               end
            end else begin
               if (pop) begin
                  q_instr_d[0] = q_instr_q[1];
                  q_pc_d[0]    = q_pc_q[1];
               end
               if (inflight_q) begin
                  if (count_after_pop[0]) begin
                     q_instr_d[1] = imem_rdata;
                     q_pc_d[1]    = inflight_pc_q;
                  end else begin
                     q_instr_d[0] = imem_rdata;
                     q_pc_d[0]    = inflight_pc_q;
                  end
                  count_d = count_after_pop + 2'd1;
               end else begin
                  count_d = count_after_pop;
               end
               // Queued + in-flight never exceeds two, so a push can never overflow
               issue      = (occ_after_pop < 3'd2);
               inflight_d = issue;
               if (issue) begin
                  inflight_pc_d = pc_q;
                  pc_d          = pc_q + PC_WIDTH'(PC_STEP);
               end
            end
         end
         S_FAULT: begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_VECTOR;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= 2'd0;
         err_q         <= 1'b0;
         q_instr_q[0]  <= '0;
         q_instr_q[1]  <= '0;
         q_pc_q[0]     <= '0;
         q_pc_q[1]     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         err_q         <= err_d;
         q_instr_q[0]  <= q_instr_d[0];
         q_instr_q[1]  <= q_instr_d[1];
         q_pc_q[0]     <= q_pc_d[0];
         q_pc_q[1]     <= q_pc_d[1];
      end
   end

   assign imem_en        = issue;
   assign imem_addr      = pc_q;
   assign out_valid      = (count_q != 2'd0);
   assign out_instr      = q_instr_q[0];
   assign out_pc         = q_pc_q[0];
   assign misaligned_err = err_q;

endmodule

// File: doc/fetch_unit_pipelined.md
Name: fetch_unit_pipelined

Overview:
- Parametrised successor to the 8-bit PC-plus-adder fetch path.
- Owns the program counter and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned instructions in a 2-entry queue toward decode with a valid/ready handshake.
- Handles redirects (branch/jump) with flush of queued and in-flight fetches, and traps misaligned targets.

Parameters:
- PC_WIDTH, 8, width of PC and memory address.
- INSTR_WIDTH, 32, instruction width.
- PC_STEP, 4, sequential PC increment.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous active-low reset (0 = in reset).
- imem_en  out  1  read request this cycle.
- imem_addr  out  PC_WIDTH  read address, equals current PC.
- imem_rdata  in  INSTR_WIDTH  read data, valid the cycle after imem_en.
- redirect_valid  in  1  one-cycle pulse: load new PC.
- redirect_target  in  PC_WIDTH  new PC.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  INSTR_WIDTH  head instruction.
- out_pc  out  PC_WIDTH  PC of head instruction.
- misaligned_err  out  1  sticky fault flag.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_VECTOR, state=IDLE, queue count=0, in-flight flag=0, misaligned_err=0.
  - out_valid=0, out_instr=0, out_pc=0, imem_en=0.
- FSM:
  - IDLE: one cycle after reset release, no issue, then RUN.
  - RUN: normal fetch.
  - FAULT: entered on misaligned redirect; no issue, queue empty, out_valid=0, exit only by reset.
- Issue rule (RUN, no redirect this cycle):
  - imem_en=1 when count + inflight - pop < 2, where pop = out_valid & out_ready.
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+PC_STEP (mod 2^PC_WIDTH; wrap-around, no flag).
  - Otherwise inflight<=0.
- Response: when inflight=1, imem_rdata and inflight_pc are written to the queue tail at the clock edge.
- Latency:
  - Issue at cycle t gives out_valid at t+2.
  - Steady-state throughput is 1 instr/cycle when out_ready=1.
- Queue:
  - 2 entries, FIFO order.
  - Simultaneous push and pop is allowed at any count.
  - Overflow is impossible by the issue rule.
  - out_instr and out_pc are stable while out_valid=1 and out_ready=0.
- Redirect (priority over everything, in RUN):
  - pc<=redirect_target, queue count<=0, inflight<=0, so the returning response is discarded.
  - imem_en=0 that cycle.
  - A pop in the same cycle is ignored: the head is flushed.
  - First post-redirect instruction appears 3 cycles after the pulse (issue at t+1, out_valid at t+3).
- Misaligned:
  - redirect_target[1:0]!=0 in RUN sets misaligned_err=1 (sticky), flushes as a redirect, and moves to FAULT. pc is not updated.
  - Redirects in IDLE or FAULT are ignored.
- Reset mid-operation: all state returns to reset values immediately, with no further imem_en until IDLE completes.
- imem_addr = pc at all times; meaningful only when imem_en=1.

Test Plan:
- Straight-line fetch: release reset, out_ready=1, memory word = address → imem_en first high cycle 2 after release; out_pc 0,4,8,12… on consecutive cycles; out_instr matches.
- Backpressure: out_ready=0 for 5 cycles after first out_valid → at most 2 issues then imem_en=0; head holds pc=0 stable; on out_ready=1, 0,4,8 delivered in order with no loss or duplication.
- Redirect with in-flight: redirect_target=0x40 pulsed while count=2 and inflight=1 → out_valid=0 next cycle; next delivered out_pc=0x40 exactly 3 cycles after the pulse, then 0x44.
- Wrap: redirect to 0xF8 with PC_WIDTH=8 → delivered PCs 0xF8, 0xFC, 0x00, 0x04.
- Misaligned: redirect_target=0x42 → misaligned_err=1, out_valid=0, imem_en=0 for all later cycles; further redirects ignored; reset clears the flag.
- Async reset mid-stream: assert reset between clock edges during streaming → outputs zero immediately; after release, fetch restarts at RESET_VECTOR (also check RESET_VECTOR=0x20).
